// File: rtl/busm.sv
// busm: memc initiator FSM that turns single core requests into one memc strobe each.
// Optional memc_busy watchdog is built when BUSM_TIMEOUT_EN is defined.

module busm #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  busm_clk,
  input  logic                  busm_reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_ready,
  output logic                  core_ack,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_err,
  output logic                  memc_read_enable,
  output logic                  memc_write_enable,
  output logic [ADDR_WIDTH-1:0] memc_addr,
  output logic [DATA_WIDTH-1:0] memc_write_data,
  input  logic [DATA_WIDTH-1:0] memc_read_data,
  input  logic                  memc_busy
);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, RD_WAIT, ACK, ERROR} state_e;

  localparam logic [2:0] RD_LAST = 3'(RD_LATENCY);

  state_e                state_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [2:0]            lat_q;
  logic                  issue_go;
  logic                  tmo_hit;

  // Strobes are gated by the live memc_busy so a busy cycle never carries a strobe.
  assign issue_go = (state_q == ISSUE) && !memc_busy;

`ifdef BUSM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_q;

  assign tmo_hit  = memc_busy && (tmo_q == TMO_LAST);
  assign core_err = (state_q == ERROR);

  always_ff @(posedge busm_clk or negedge busm_reset) begin
    if (!busm_reset) begin
      tmo_q <= '0;
    end else if ((state_q == IDLE) && core_req) begin
      tmo_q <= '0;
    end else if (((state_q == INIT) || (state_q == ISSUE)) && memc_busy) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign core_err = 1'b0;
`endif

  always_ff @(posedge busm_clk or negedge busm_reset) begin
    if (!busm_reset) begin
      state_q <= INIT;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (!memc_busy)   state_q <= IDLE;
          else if (tmo_hit) state_q <= ERROR;
        end
        IDLE: begin
          if (core_req) begin
            we_q    <= core_we;
            addr_q  <= core_addr;
            wdata_q <= core_wdata;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!memc_busy) begin
            if (we_q) begin
              state_q <= ACK;
            end else begin
              lat_q   <= 3'd1;
              state_q <= RD_WAIT;
            end
          end else if (tmo_hit) begin
            state_q <= ERROR;
          end
        end
        RD_WAIT: begin
          // lat_q counts cycles since the issue cycle; data is valid at issue+RD_LATENCY.
          if (lat_q == RD_LAST) begin
            rdata_q <= memc_read_data;
            state_q <= ACK;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        ACK:     state_q <= IDLE;
        ERROR:   state_q <= ERROR;
        default: state_q <= INIT;
      endcase
    end
  end

  assign core_ready        = (state_q == IDLE);
  assign core_ack          = (state_q == ACK);
  assign core_rdata        = rdata_q;
  assign memc_addr         = addr_q;
  assign memc_write_data   = wdata_q;
  assign memc_read_enable  = issue_go && !we_q;
  assign memc_write_enable = issue_go && we_q;

endmodule

// File: tb/tb_busm.sv
// Self-checking bench for busm: vector table, reset/abort/timeout sequences, and
// randomized transactions checked against a memory-level reference model.

module tb_busm;

  localparam int RL  = 2;
  localparam int TMO = 10;
`ifdef BUSM_TIMEOUT_EN
  localparam int INIT_BUSY = 8;
`else
  localparam int INIT_BUSY = 40;
`endif

  logic        busm_clk = 1'b0;
  logic        busm_reset;
  logic        core_req, core_we;
  logic [15:0] core_addr;
  logic [7:0]  core_wdata;
  logic        core_ready, core_ack, core_err;
  logic [7:0]  core_rdata;
  logic        memc_read_enable, memc_write_enable;
  logic [15:0] memc_addr;
  logic [7:0]  memc_write_data;
  logic [7:0]  memc_read_data = '0;
  logic        memc_busy;

  int checks = 0;
  int errors = 0;

  busm #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(16),
    .RD_LATENCY(RL),
    .TIMEOUT(TMO)
  ) dut (
    .busm_clk(busm_clk),
    .busm_reset(busm_reset),
    .core_req(core_req),
    .core_we(core_we),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_ready(core_ready),
    .core_ack(core_ack),
    .core_rdata(core_rdata),
    .core_err(core_err),
    .memc_read_enable(memc_read_enable),
    .memc_write_enable(memc_write_enable),
    .memc_addr(memc_addr),
    .memc_write_data(memc_write_data),
    .memc_read_data(memc_read_data),
    .memc_busy(memc_busy)
  );

  always #5 busm_clk = ~busm_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // memc model: byte store, read data valid only in cycle issue+RL, noise otherwise.
  logic [7:0]  memc_mem [logic [15:0]];
  int          cyc = 0;
  int          due_cyc = -100;
  logic [7:0]  due_val;
  logic        rd_s = 1'b0, wr_s = 1'b0;
  logic [15:0] a_s;
  logic [7:0]  d_s;

  always @(negedge busm_clk) begin
    rd_s = memc_read_enable;
    wr_s = memc_write_enable;
    a_s  = memc_addr;
    d_s  = memc_write_data;
  end

  always @(posedge busm_clk) begin
    cyc++;
    if (wr_s) memc_mem[a_s] = d_s;
    if (rd_s) begin
      due_cyc = cyc - 1 + RL;
      due_val = memc_mem.exists(a_s) ? memc_mem[a_s] : init_val(a_s);
    end
    #1;
    memc_read_data = (cyc == due_cyc) ? due_val : 8'($urandom);
  end

  always @(negedge busm_clk) begin
    if (busm_reset) begin
      check("strobe_mutex", 32'(memc_read_enable & memc_write_enable), 0);
      check("strobe_while_busy", 32'((memc_read_enable | memc_write_enable) & memc_busy), 0);
    end
  end

  // Reference: what a read returns given all completed core writes.
  logic [7:0] ref_mem [logic [15:0]];

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic do_txn(input logic we, input logic [15:0] a, input logic [7:0] d, input int busy,
                        output int ack_cyc, output logic [7:0] rd);
    int strobes = 0;
    int stb_cyc = -1;
    ack_cyc = -1;
    rd      = '0;
    for (int w = 0; w < 50 && !core_ready; w++) begin
      @(posedge busm_clk); #1;
    end
    check("ready_wait", 32'(core_ready), 1);
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d; memc_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        core_req   = 1'b0;
        core_we    = 1'($urandom);
        core_addr  = 16'($urandom);
        core_wdata = 8'($urandom);
        memc_busy  = (c <= busy);
      end
      @(negedge busm_clk);
      if (c == 0) check("ready_c0", 32'(core_ready), 1);
      if (c == 1) check("ready_c1", 32'(core_ready), 0);
      if (c >= 1 && ack_cyc < 0) begin
        check("addr_hold", 32'(memc_addr), 32'(a));
        check("wdata_hold", 32'(memc_write_data), 32'(d));
      end
      if (memc_read_enable || memc_write_enable) begin
        strobes++;
        stb_cyc = c;
        check("strobe_type", 32'({memc_write_enable, memc_read_enable}), we ? 2 : 1);
      end
      if (ack_cyc >= 0) begin
        check("ack_pulse", 32'(core_ack), 0);
        check("ready_after", 32'(core_ready), 1);
        @(posedge busm_clk); #1;
        break;
      end
      if (core_ack) begin
        ack_cyc = c;
        rd      = core_rdata;
      end
      @(posedge busm_clk); #1;
    end
    check("strobe_count", strobes, 1);
    check("strobe_cycle", stb_cyc, busy + 1);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          busy;
    int          exp_ack;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t        vecs [9];
  int          ack, bad, acks, err_cyc, drop, stb, rdy;
  logic [7:0]  rd, last_rd;
  logic        r_we;
  logic [15:0] r_a;
  logic [7:0]  r_d;
  int          r_b;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 16'h1234, 8'hA5, 0, 2, 8'h00};
    vecs[1] = '{1'b1, 16'h00FF, 8'h3C, 0, 2, 8'h00};
    vecs[2] = '{1'b0, 16'h00FF, 8'h00, 0, 4, 8'h3C};
    vecs[3] = '{1'b0, 16'h1234, 8'h00, 0, 4, 8'hA5};
    vecs[4] = '{1'b1, 16'hBEEF, 8'h00, 5, 7, 8'hA5};
    vecs[5] = '{1'b0, 16'hBEEF, 8'h00, 5, 9, 8'h00};
    vecs[6] = '{1'b1, 16'hFFFF, 8'hFF, 1, 3, 8'h00};
    vecs[7] = '{1'b0, 16'hFFFF, 8'h00, 1, 5, 8'hFF};
    vecs[8] = '{1'b0, 16'h0000, 8'h00, 0, 4, 8'h5A};

    busm_reset = 1'b0; core_req = 1'b0; core_we = 1'b0;
    core_addr = '0; core_wdata = '0; memc_busy = 1'b1;
    repeat (2) @(posedge busm_clk);
    #1;
    check("rst_flags", 32'({core_ready, core_ack, core_err, memc_read_enable, memc_write_enable}), 0);
    check("rst_rdata", 32'(core_rdata), 0);
    check("rst_addr", 32'(memc_addr), 0);
    check("rst_wdata", 32'(memc_write_data), 0);

    // Long memc busy after reset: block must stay in INIT.
    busm_reset = 1'b1;
    bad = 0;
    for (int i = 0; i < INIT_BUSY; i++) begin
      @(negedge busm_clk);
      if (core_ready || memc_read_enable || memc_write_enable) bad++;
      @(posedge busm_clk); #1;
    end
    check("init_hold", bad, 0);
    memc_busy = 1'b0;
    @(negedge busm_clk);
    check("init_busy_fall", 32'(core_ready), 0);
    @(posedge busm_clk); #1;
    check("init_ready", 32'(core_ready), 1);

    last_rd = '0;
    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].busy, ack, rd);
      check("vec_ack", ack, vecs[i].exp_ack);
      check("vec_rdata", 32'(rd), 32'(vecs[i].exp_rdata));
      if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].wdata;
      else            last_rd = vecs[i].exp_rdata;
    end

    // Reset during RD_WAIT aborts the read with no ack.
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0F0F; memc_busy = 1'b0;
    @(posedge busm_clk); #1;
    core_req = 1'b0;
    @(posedge busm_clk); #2;
    busm_reset = 1'b0;
    #1;
    check("abort_flags", 32'({core_ready, core_ack, core_err, memc_read_enable, memc_write_enable}), 0);
    check("abort_rdata", 32'(core_rdata), 0);
    check("abort_addr", 32'(memc_addr), 0);
    check("abort_wdata", 32'(memc_write_data), 0);
    repeat (2) @(posedge busm_clk);
    #1;
    busm_reset = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge busm_clk);
      if (core_ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    @(posedge busm_clk); #1;
    do_txn(1'b0, 16'h0F0F, 8'h00, 0, ack, rd);
    check("post_abort_ack", ack, RL + 2);
    check("post_abort_rdata", 32'(rd), 32'(ref_read(16'h0F0F)));
    last_rd = rd;

`ifdef BUSM_TIMEOUT_EN
    for (int w = 0; w < 50 && !core_ready; w++) begin
      @(posedge busm_clk); #1;
    end
    core_req = 1'b1; core_we = 1'b1; core_addr = 16'h7777; core_wdata = 8'h11;
    @(posedge busm_clk); #1;
    core_req = 1'b0; memc_busy = 1'b1;
    err_cyc = -1; drop = 0; stb = 0; rdy = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge busm_clk);
      if (core_err && err_cyc < 0) err_cyc = c;
      if (err_cyc >= 0 && !core_err) drop++;
      if (memc_read_enable || memc_write_enable) stb++;
      if (core_ready) rdy++;
      @(posedge busm_clk); #1;
    end
    check("tmo_err_cycle", err_cyc, TMO + 1);
    check("tmo_err_sticky", drop, 0);
    check("tmo_no_strobe", stb, 0);
    check("tmo_not_ready", rdy, 0);
    busm_reset = 1'b0;
    #1;
    check("tmo_err_clear", 32'(core_err), 0);
    memc_busy = 1'b0;
    @(posedge busm_clk); #1;
    busm_reset = 1'b1;
    @(posedge busm_clk); #1;
    last_rd = '0;
`endif

    for (int n = 0; n < 40; n++) begin
      r_we = 1'($urandom_range(0, 1));
      r_a  = {4{4'($urandom_range(0, 15))}};
      r_d  = 8'($urandom);
      r_b  = int'($urandom_range(0, 4));
      do_txn(r_we, r_a, r_d, r_b, ack, rd);
      check("rnd_ack", ack, (r_we ? 2 : RL + 2) + r_b);
      check("rnd_rdata", 32'(rd), 32'(r_we ? last_rd : ref_read(r_a)));
      if (r_we) ref_mem[r_a] = r_d;
      else      last_rd = ref_read(r_a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
